// File: rtl/reservation_station_n.sv
// Parametrised reservation station: buffers renamed instructions, snoops wakeup
// broadcasts and issues the oldest ready row per FU-class port each cycle.
module reservation_station_n #(
   parameter int ENTRIES = 16,
   parameter int DW      = 2,
   parameter int NI      = 3,
   parameter int WW      = 2,
   parameter int PRW     = 6,
   parameter int PW      = 32,
   localparam int FUW    = (NI > 1) ? $clog2(NI) : 1,
   localparam int FCW    = $clog2(ENTRIES + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [DW-1:0]     i_disp_valid,
   input  logic [DW*FUW-1:0] i_disp_fu,
   input  logic [DW*PRW-1:0] i_disp_src1,
   input  logic [DW*PRW-1:0] i_disp_src2,
   input  logic [DW-1:0]     i_disp_src1_rdy,
   input  logic [DW-1:0]     i_disp_src2_rdy,
   input  logic [DW*PRW-1:0] i_disp_dest,
   input  logic [DW*PW-1:0]  i_disp_payload,
   output logic              o_disp_ready,
   input  logic [WW-1:0]     i_wake_valid,
   input  logic [WW*PRW-1:0] i_wake_preg,
   input  logic [NI-1:0]     i_issue_stall,
   output logic [NI-1:0]     o_issue_valid,
   output logic [NI*PRW-1:0] o_issue_src1,
   output logic [NI*PRW-1:0] o_issue_src2,
   output logic [NI*PRW-1:0] o_issue_dest,
   output logic [NI*PW-1:0]  o_issue_payload,
   input  logic              i_flush,
   output logic [FCW-1:0]    o_free_count
);

   localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam int SW = (DW > 1) ? $clog2(DW) : 1;

   logic [ENTRIES-1:0] valid;
   logic [ENTRIES-1:0] r_rdy1, r_rdy2;
   logic [FUW-1:0]     r_fu    [ENTRIES];
   logic [PRW-1:0]     r_src1  [ENTRIES];
   logic [PRW-1:0]     r_src2  [ENTRIES];
   logic [PRW-1:0]     r_dest  [ENTRIES];
   logic [PW-1:0]      r_pay   [ENTRIES];
   // age[r][j] set means row r is older than row j
   logic [ENTRIES-1:0] age     [ENTRIES];
   logic [ENTRIES-1:0] age_nxt [ENTRIES];
   logic [FCW-1:0]     free_count;

   logic [ENTRIES-1:0] new_row;
   logic [SW-1:0]      new_slot [ENTRIES];
   logic [FCW-1:0]     n_disp, n_iss;
   logic [ENTRIES-1:0] issued;
   logic [NI-1:0]      sel_any;
   logic [IW-1:0]      sel_idx  [NI];
   logic               disp_ok;

   function automatic logic woken(input logic [PRW-1:0] p,
                                  input logic [WW-1:0] wv,
                                  input logic [WW*PRW-1:0] wp);
      logic hit;
      hit = (p == '0);
      for (int w = 0; w < WW; w++) begin
         if (wv[w] && (wp[w*PRW +: PRW] == p)) hit = 1'b1;
      end
      return hit;
   endfunction

   assign o_disp_ready = (free_count >= FCW'(DW));
   assign o_free_count = free_count;
   assign disp_ok      = o_disp_ready & ~i_flush;

   // Slots claim the lowest free rows in slot order; rows draining this edge stay busy.
   always_comb begin
      logic [ENTRIES-1:0] avail;
      logic               found;
      avail   = ~valid;
      new_row = '0;
      n_disp  = '0;
      found   = 1'b0;
      for (int r = 0; r < ENTRIES; r++) new_slot[r] = '0;
      for (int s = 0; s < DW; s++) begin
         found = 1'b0;
         for (int r = 0; r < ENTRIES; r++) begin
            if (!found && avail[r] && i_disp_valid[s] && disp_ok) begin
               found       = 1'b1;
               avail[r]    = 1'b0;
               new_row[r]  = 1'b1;
               new_slot[r] = SW'(s);
            end
         end
         if (found) n_disp = n_disp + FCW'(1);
      end
   end

   always_comb begin
      for (int r = 0; r < ENTRIES; r++) begin
         for (int j = 0; j < ENTRIES; j++) begin
            if (new_row[r] && new_row[j])
               age_nxt[r][j] = (new_slot[r] < new_slot[j]);
            else if (new_row[r])
               age_nxt[r][j] = 1'b0;
            else if (new_row[j])
               age_nxt[r][j] = 1'b1;
            else
               age_nxt[r][j] = age[r][j];
         end
      end
   end

   always_comb begin
      logic [ENTRIES-1:0] elig;
      logic               blocked;
      issued  = '0;
      n_iss   = '0;
      sel_any = '0;
      elig    = '0;
      blocked = 1'b0;
      for (int k = 0; k < NI; k++) begin
         sel_idx[k] = '0;
         for (int i = 0; i < ENTRIES; i++)
            elig[i] = valid[i] & r_rdy1[i] & r_rdy2[i] & (r_fu[i] == FUW'(k))
                      & ~i_issue_stall[k];
         for (int i = 0; i < ENTRIES; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < ENTRIES; j++) begin
               if (j != i && elig[j] && age[j][i]) blocked = 1'b1;
            end
            if (elig[i] && !blocked) begin
               sel_any[k] = 1'b1;
               sel_idx[k] = IW'(i);
            end
         end
         if (sel_any[k]) begin
            issued[sel_idx[k]] = 1'b1;
            n_iss              = n_iss + FCW'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid           <= '0;
         o_issue_valid   <= '0;
         o_issue_src1    <= '0;
         o_issue_src2    <= '0;
         o_issue_dest    <= '0;
         o_issue_payload <= '0;
         free_count      <= FCW'(ENTRIES);
         for (int r = 0; r < ENTRIES; r++) age[r] <= '0;
      end else if (i_flush) begin
         valid         <= '0;
         o_issue_valid <= '0;
         free_count    <= FCW'(ENTRIES);
      end else begin
         valid      <= (valid & ~issued) | new_row;
         free_count <= free_count + n_iss - n_disp;
         for (int r = 0; r < ENTRIES; r++) age[r] <= age_nxt[r];
         for (int k = 0; k < NI; k++) begin
            if (!i_issue_stall[k]) begin
               o_issue_valid[k] <= sel_any[k];
               if (sel_any[k]) begin
                  o_issue_src1[k*PRW +: PRW]  <= r_src1[sel_idx[k]];
                  o_issue_src2[k*PRW +: PRW]  <= r_src2[sel_idx[k]];
                  o_issue_dest[k*PRW +: PRW]  <= r_dest[sel_idx[k]];
                  o_issue_payload[k*PW +: PW] <= r_pay[sel_idx[k]];
               end
            end
         end
      end
   end

   // Row contents need no reset: nothing reads them unless the row is valid.
   always_ff @(posedge i_clk) begin
      for (int r = 0; r < ENTRIES; r++) begin
         if (new_row[r]) begin
            r_fu[r]   <= i_disp_fu[new_slot[r]*FUW +: FUW];
            r_src1[r] <= i_disp_src1[new_slot[r]*PRW +: PRW];
            r_src2[r] <= i_disp_src2[new_slot[r]*PRW +: PRW];
            r_dest[r] <= i_disp_dest[new_slot[r]*PRW +: PRW];
            r_pay[r]  <= i_disp_payload[new_slot[r]*PW +: PW];
            r_rdy1[r] <= i_disp_src1_rdy[new_slot[r]] |
                         woken(i_disp_src1[new_slot[r]*PRW +: PRW], i_wake_valid, i_wake_preg);
            r_rdy2[r] <= i_disp_src2_rdy[new_slot[r]] |
                         woken(i_disp_src2[new_slot[r]*PRW +: PRW], i_wake_valid, i_wake_preg);
         end else begin
            if (woken(r_src1[r], i_wake_valid, i_wake_preg)) r_rdy1[r] <= 1'b1;
            if (woken(r_src2[r], i_wake_valid, i_wake_preg)) r_rdy2[r] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_reservation_station_n.sv
// Directed bench for reservation_station_n: a sequence-number model of the
// station is stepped every edge and compared against the DUT each cycle.
module tb_reservation_station_n;

   localparam int ENTRIES = 16;
   localparam int DW      = 2;
   localparam int NI      = 3;
   localparam int WW      = 2;
   localparam int PRW     = 6;
   localparam int PW      = 32;
   localparam int FUW     = 2;
   localparam int FCW     = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic [DW-1:0]     disp_valid;
   logic [DW*FUW-1:0] disp_fu;
   logic [DW*PRW-1:0] disp_src1, disp_src2, disp_dest;
   logic [DW-1:0]     disp_src1_rdy, disp_src2_rdy;
   logic [DW*PW-1:0]  disp_payload;
   logic              disp_ready;
   logic [WW-1:0]     wake_valid;
   logic [WW*PRW-1:0] wake_preg;
   logic [NI-1:0]     issue_stall;
   logic [NI-1:0]     issue_valid;
   logic [NI*PRW-1:0] issue_src1, issue_src2, issue_dest;
   logic [NI*PW-1:0]  issue_payload;
   logic              flush;
   logic [FCW-1:0]    free_count;

   always #5 clk = ~clk;

   reservation_station_n #(
      .ENTRIES(ENTRIES), .DW(DW), .NI(NI), .WW(WW), .PRW(PRW), .PW(PW)
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_disp_valid(disp_valid), .i_disp_fu(disp_fu),
      .i_disp_src1(disp_src1), .i_disp_src2(disp_src2),
      .i_disp_src1_rdy(disp_src1_rdy), .i_disp_src2_rdy(disp_src2_rdy),
      .i_disp_dest(disp_dest), .i_disp_payload(disp_payload),
      .o_disp_ready(disp_ready),
      .i_wake_valid(wake_valid), .i_wake_preg(wake_preg),
      .i_issue_stall(issue_stall),
      .o_issue_valid(issue_valid), .o_issue_src1(issue_src1),
      .o_issue_src2(issue_src2), .o_issue_dest(issue_dest),
      .o_issue_payload(issue_payload),
      .i_flush(flush), .o_free_count(free_count)
   );

   int checks = 0;
   int errors = 0;

   // Model: each row carries a dispatch sequence number; smaller is older.
   bit          m_valid [ENTRIES];
   int          m_fu    [ENTRIES];
   int          m_s1    [ENTRIES];
   int          m_s2    [ENTRIES];
   bit          m_r1    [ENTRIES];
   bit          m_r2    [ENTRIES];
   int          m_dest  [ENTRIES];
   logic [31:0] m_pay   [ENTRIES];
   int          m_seq   [ENTRIES];
   int          next_seq = 0;
   bit          m_ov    [NI];
   int          m_os1   [NI];
   int          m_os2   [NI];
   int          m_odest [NI];
   logic [31:0] m_opay  [NI];
   int          m_free  = ENTRIES;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic bit wk(input int p);
      bit hit;
      hit = (p == 0);
      for (int w = 0; w < WW; w++)
         if (wake_valid[w] && int'(wake_preg[w*PRW +: PRW]) == p) hit = 1'b1;
      return hit;
   endfunction

   task automatic model_step();
      bit freeing [ENTRIES];
      int best;
      bit placed;
      for (int i = 0; i < ENTRIES; i++) freeing[i] = 1'b0;
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
         for (int k = 0; k < NI; k++) begin
            m_ov[k] = 1'b0; m_os1[k] = 0; m_os2[k] = 0; m_odest[k] = 0; m_opay[k] = '0;
         end
         m_free = ENTRIES;
      end else if (flush) begin
         for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
         for (int k = 0; k < NI; k++) m_ov[k] = 1'b0;
         m_free = ENTRIES;
      end else begin
         for (int k = 0; k < NI; k++) begin
            if (!issue_stall[k]) begin
               best = -1;
               for (int i = 0; i < ENTRIES; i++)
                  if (m_valid[i] && m_r1[i] && m_r2[i] && m_fu[i] == k &&
                      (best < 0 || m_seq[i] < m_seq[best])) best = i;
               if (best >= 0) begin
                  m_ov[k] = 1'b1; m_os1[k] = m_s1[best]; m_os2[k] = m_s2[best];
                  m_odest[k] = m_dest[best]; m_opay[k] = m_pay[best];
                  freeing[best] = 1'b1;
               end else m_ov[k] = 1'b0;
            end
         end
         for (int i = 0; i < ENTRIES; i++) if (m_valid[i]) begin
            if (wk(m_s1[i])) m_r1[i] = 1'b1;
            if (wk(m_s2[i])) m_r2[i] = 1'b1;
         end
         if (m_free >= DW) begin
            for (int s = 0; s < DW; s++) if (disp_valid[s]) begin
               placed = 1'b0;
               for (int i = 0; i < ENTRIES; i++) if (!placed && !m_valid[i]) begin
                  placed = 1'b1;
                  m_valid[i] = 1'b1;
                  m_fu[i]   = int'(disp_fu[s*FUW +: FUW]);
                  m_s1[i]   = int'(disp_src1[s*PRW +: PRW]);
                  m_s2[i]   = int'(disp_src2[s*PRW +: PRW]);
                  m_dest[i] = int'(disp_dest[s*PRW +: PRW]);
                  m_pay[i]  = disp_payload[s*PW +: PW];
                  m_r1[i]   = disp_src1_rdy[s] || wk(m_s1[i]);
                  m_r2[i]   = disp_src2_rdy[s] || wk(m_s2[i]);
                  m_seq[i]  = next_seq++;
               end
            end
         end
         for (int i = 0; i < ENTRIES; i++) if (freeing[i]) m_valid[i] = 1'b0;
         m_free = 0;
         for (int i = 0; i < ENTRIES; i++) if (!m_valid[i]) m_free++;
      end
   endtask

   task automatic compare();
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("p%0d_valid", k), 32'(issue_valid[k]), 32'(m_ov[k]));
         if (m_ov[k]) begin
            chk($sformatf("p%0d_src1", k), 32'(issue_src1[k*PRW +: PRW]), m_os1[k]);
            chk($sformatf("p%0d_src2", k), 32'(issue_src2[k*PRW +: PRW]), m_os2[k]);
            chk($sformatf("p%0d_dest", k), 32'(issue_dest[k*PRW +: PRW]), m_odest[k]);
            chk($sformatf("p%0d_payload", k), issue_payload[k*PW +: PW], m_opay[k]);
         end
      end
      chk("free_count", 32'(free_count), m_free);
      chk("disp_ready", 32'(disp_ready), 32'(m_free >= DW));
   endtask

   task automatic clear_pulse();
      disp_valid = '0; disp_fu = '0; disp_src1 = '0; disp_src2 = '0;
      disp_src1_rdy = '0; disp_src2_rdy = '0; disp_dest = '0; disp_payload = '0;
      wake_valid = '0; wake_preg = '0; flush = 1'b0;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare();
      clear_pulse();
   endtask

   task automatic slot(input int s, input int fu, input int s1, input bit r1,
                       input int s2, input bit r2, input int dest, input logic [31:0] pay);
      disp_valid[s]              = 1'b1;
      disp_fu[s*FUW +: FUW]      = FUW'(fu);
      disp_src1[s*PRW +: PRW]    = PRW'(s1);
      disp_src2[s*PRW +: PRW]    = PRW'(s2);
      disp_src1_rdy[s]           = r1;
      disp_src2_rdy[s]           = r2;
      disp_dest[s*PRW +: PRW]    = PRW'(dest);
      disp_payload[s*PW +: PW]   = pay;
   endtask

   task automatic wake(input int w, input int p);
      wake_valid[w]           = 1'b1;
      wake_preg[w*PRW +: PRW] = PRW'(p);
   endtask

   task automatic load5();
      slot(0, 0, 50, 0, 1, 1, 1, 32'h50); slot(1, 0, 51, 0, 1, 1, 2, 32'h51); tick();
      slot(0, 0, 52, 0, 1, 1, 3, 32'h52); slot(1, 0, 53, 0, 1, 1, 4, 32'h53); tick();
      slot(0, 0, 54, 0, 1, 1, 5, 32'h54); tick();
      chk("load5_free", 32'(free_count), 11);
   endtask

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      issue_stall = '0;
      rst = 1'b1;
      clear_pulse();
      tick();
      tick();
      rst = 1'b0;
      chk("rst_valid", 32'(issue_valid), 0);
      chk("rst_free", 32'(free_count), 16);
      chk("rst_ready", 32'(disp_ready), 1);

      // ready dispatch
      slot(0, 0, 3, 1, 4, 1, 10, 32'hA5);
      tick();
      chk("t1_free_after_disp", 32'(free_count), 15);
      tick();
      chk("t1_valid0", 32'(issue_valid[0]), 1);
      chk("t1_dest", 32'(issue_dest[5:0]), 10);
      chk("t1_payload", issue_payload[31:0], 32'hA5);
      chk("t1_free", 32'(free_count), 16);
      tick();
      chk("t1_valid0_drop", 32'(issue_valid[0]), 0);

      // wakeup and same-cycle bypass
      slot(0, 1, 7, 0, 5, 1, 11, 32'h11);
      tick();
      repeat (3) tick();
      chk("t2_wait", 32'(issue_valid), 0);
      wake(0, 7);
      tick();
      tick();
      chk("t2_valid1", 32'(issue_valid[1]), 1);
      chk("t2_dest", 32'(issue_dest[11:6]), 11);
      slot(0, 1, 7, 0, 5, 1, 12, 32'h12);
      wake(1, 7);
      tick();
      tick();
      chk("t2_bypass_valid", 32'(issue_valid[1]), 1);
      chk("t2_bypass_dest", 32'(issue_dest[11:6]), 12);

      // age order B, A, C
      slot(0, 0, 9, 0, 1, 1, 20, 32'h20);
      slot(1, 0, 1, 1, 2, 1, 21, 32'h21);
      tick();
      slot(0, 0, 9, 0, 3, 1, 22, 32'h22);
      wake(0, 9);
      tick();
      chk("t3_first", 32'(issue_dest[5:0]), 21);
      tick();
      chk("t3_second", 32'(issue_dest[5:0]), 20);
      tick();
      chk("t3_third", 32'(issue_dest[5:0]), 22);
      chk("t3_third_valid", 32'(issue_valid[0]), 1);
      tick();
      chk("t3_idle", 32'(issue_valid[0]), 0);

      // full station and back-pressure
      for (int g = 0; g < 8; g++) begin
         slot(0, 0, 40 + 2*g, 0, 1, 1, 32 + 2*g, 32'(2*g));
         slot(1, 0, 41 + 2*g, 0, 1, 1, 33 + 2*g, 32'(2*g + 1));
         tick();
      end
      chk("t4_full_free", 32'(free_count), 0);
      chk("t4_full_ready", 32'(disp_ready), 0);
      slot(0, 0, 1, 1, 2, 1, 60, 32'h60);
      slot(1, 0, 1, 1, 2, 1, 61, 32'h61);
      tick();
      chk("t4_dropped_free", 32'(free_count), 0);
      wake(0, 40);
      tick();
      tick();
      chk("t4_one_dest", 32'(issue_dest[5:0]), 32);
      chk("t4_one_free", 32'(free_count), 1);
      chk("t4_one_ready", 32'(disp_ready), 0);
      wake(0, 41);
      tick();
      tick();
      chk("t4_two_dest", 32'(issue_dest[5:0]), 33);
      chk("t4_two_free", 32'(free_count), 2);
      chk("t4_two_ready", 32'(disp_ready), 1);
      flush = 1'b1;
      tick();
      chk("t4_flush_free", 32'(free_count), 16);

      // stall holds port 2
      slot(0, 2, 1, 1, 2, 1, 29, 32'h29);
      tick();
      slot(0, 2, 1, 1, 2, 1, 30, 32'h30);
      slot(1, 2, 1, 1, 2, 1, 31, 32'h31);
      tick();
      chk("t5_pre_dest", 32'(issue_dest[17:12]), 29);
      issue_stall = 3'b100;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("t5_hold_valid", 32'(issue_valid[2]), 1);
         chk("t5_hold_dest", 32'(issue_dest[17:12]), 29);
         chk("t5_hold_payload", issue_payload[95:64], 32'h29);
      end
      issue_stall = '0;
      tick();
      chk("t5_older", 32'(issue_dest[17:12]), 30);
      tick();
      chk("t5_younger", 32'(issue_dest[17:12]), 31);
      tick();
      chk("t5_idle", 32'(issue_valid[2]), 0);

      // flush mid-operation
      load5();
      slot(0, 0, 1, 1, 2, 1, 40, 32'h40);
      wake(0, 50);
      flush = 1'b1;
      tick();
      chk("t6_flush_free", 32'(free_count), 16);
      chk("t6_flush_valid", 32'(issue_valid), 0);
      tick();
      chk("t6_flush_next_valid", 32'(issue_valid), 0);
      chk("t6_flush_next_free", 32'(free_count), 16);

      // reset mid-operation
      load5();
      slot(0, 0, 1, 1, 2, 1, 40, 32'h40);
      wake(0, 50);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_rst_free", 32'(free_count), 16);
      chk("t6_rst_valid", 32'(issue_valid), 0);
      tick();
      chk("t6_rst_next_valid", 32'(issue_valid), 0);
      chk("t6_rst_next_free", 32'(free_count), 16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
